// File: rtl/rate_sel_pkg.sv
// -----------------------------------------------------------------------------
// rate_sel_pkg
// Shared types for the rate selector slice.
//   dir_e  : shift direction requested in a cycle (none / left / right).
//   hold_e : state of the button hold tracker (idle / held).
// -----------------------------------------------------------------------------
package rate_sel_pkg;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } dir_e;

    typedef enum logic {
        HOLD_IDLE = 1'b0,
        HOLD_HELD = 1'b1
    } hold_e;

endpackage

// File: rtl/blink_divider.sv
// -----------------------------------------------------------------------------
// blink_divider
// Counts beat strobes and toggles blink every 2^index beats.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (count = 0, blink = 0)
//   beat   : single-cycle time-base strobe
//   index  : selected rate index, half-period = 2^index beats
//   clear  : selection changed this cycle; restart the half-period
//   blink  : divided blink waveform (registered)
// -----------------------------------------------------------------------------
module blink_divider #(
    parameter  int WIDTH = 4,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beat,
    input  logic [IW-1:0] index,
    input  logic          clear,
    output logic          blink
);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] term_s;
    logic             blink_r;

    // Terminal count for the current index: 2^index - 1 (fits in WIDTH bits).
    always_comb begin
        term_s = (ONE_W << index) - ONE_W;
    end

    // Beat counter and blink toggle; a selection change restarts the period
    // but leaves the blink level untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            blink_r <= 1'b0;
        end else if (clear) begin
            count_r <= '0;
            blink_r <= blink_r;
        end else if (beat) begin
            if (count_r == term_s) begin
                count_r <= '0;
                blink_r <= ~blink_r;
            end else begin
                count_r <= count_r + ONE_W;
                blink_r <= blink_r;
            end
        end else begin
            count_r <= count_r;
            blink_r <= blink_r;
        end
    end

    assign blink = blink_r;

endmodule

// File: rtl/rate_selector.sv
// -----------------------------------------------------------------------------
// rate_selector
// One-hot rate selector driven by debounced left/right button levels, with an
// integrated blink divider whose half-period is 2^index beats.
//
// Optional build macro: RATE_AUTOREPEAT_EN
//   When defined, a button held in the HELD state issues one extra shift in
//   the held direction every REPEAT_BEATS beats.
//   When undefined, exactly one shift is produced per rising edge.
//
// Parameters:
//   WIDTH        : number of rate positions (>= 2)
//   RESET_INDEX  : index selected after reset (< WIDTH)
//   WRAP         : 1 = wrap at the ends, 0 = saturate at the ends
//   REPEAT_BEATS : auto-repeat interval in beats (macro builds only)
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset, highest priority
//   beat         : single-cycle time-base strobe
//   shift_left   : debounced level, rising edge increments index
//   shift_right  : debounced level, rising edge decrements index
//   out          : one-hot selection, out == 1 << index (registered)
//   index        : binary selected index (registered)
//   blink        : divided blink waveform (registered)
// -----------------------------------------------------------------------------
module rate_selector
    import rate_sel_pkg::*;
#(
    parameter  int WIDTH        = 4,
    parameter  int RESET_INDEX  = 0,
    parameter  int WRAP         = 1,
    parameter  int REPEAT_BEATS = 8,
    localparam int IW           = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat,
    input  logic             shift_left,
    input  logic             shift_right,
    output logic [WIDTH-1:0] out,
    output logic [IW-1:0]    index,
    output logic             blink
);

    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [IW-1:0]    IDX_MAX = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    IDX_RST = IW'(RESET_INDEX);

    logic             prev_l_r;
    logic             prev_r_r;
    logic             press_l_s;
    logic             press_r_s;
    dir_e             press_dir_s;
    dir_e             shift_dir_s;
    logic             sel_change_s;
    logic             rep_fire_s;

    logic [IW-1:0]    idx_r;
    logic [IW-1:0]    idx_nxt_s;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_nxt_s;

    hold_e            hold_r;
    hold_e            hold_nxt_s;
    dir_e             held_dir_r;
    dir_e             held_dir_nxt_s;
    logic             leave_s;

    // Button history; set to 1 in reset so a level held through reset is
    // not mistaken for a fresh press when reset drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_l_r <= 1'b1;
            prev_r_r <= 1'b1;
        end else begin
            prev_l_r <= shift_left;
            prev_r_r <= shift_right;
        end
    end

    assign press_l_s = shift_left  & ~prev_l_r;
    assign press_r_s = shift_right & ~prev_r_r;

    // Resolve the presses of this cycle into a single direction; a
    // simultaneous left+right press cancels out.
    always_comb begin
        press_dir_s = DIR_NONE;
        if (press_l_s && !press_r_s) begin
            press_dir_s = DIR_LEFT;
        end else if (press_r_s && !press_l_s) begin
            press_dir_s = DIR_RIGHT;
        end else begin
            press_dir_s = DIR_NONE;
        end
    end

    // Hold tracker next state: leaves HELD on release of the held button or
    // on a rising edge of the opposite one.
    always_comb begin
        hold_nxt_s     = hold_r;
        held_dir_nxt_s = held_dir_r;
        leave_s        = 1'b0;
        case (hold_r)
            HOLD_IDLE: begin
                if (press_dir_s != DIR_NONE) begin
                    hold_nxt_s     = HOLD_HELD;
                    held_dir_nxt_s = press_dir_s;
                end else begin
                    hold_nxt_s     = HOLD_IDLE;
                    held_dir_nxt_s = DIR_NONE;
                end
            end
            HOLD_HELD: begin
                if (held_dir_r == DIR_LEFT) begin
                    leave_s = ~shift_left | press_r_s;
                end else if (held_dir_r == DIR_RIGHT) begin
                    leave_s = ~shift_right | press_l_s;
                end else begin
                    leave_s = 1'b1;
                end
                if (leave_s) begin
                    hold_nxt_s     = HOLD_IDLE;
                    held_dir_nxt_s = DIR_NONE;
                end else begin
                    hold_nxt_s     = HOLD_HELD;
                    held_dir_nxt_s = held_dir_r;
                end
            end
            default: begin
                hold_nxt_s     = HOLD_IDLE;
                held_dir_nxt_s = DIR_NONE;
            end
        endcase
    end

    // Hold tracker state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r     <= HOLD_IDLE;
            held_dir_r <= DIR_NONE;
        end else begin
            hold_r     <= hold_nxt_s;
            held_dir_r <= held_dir_nxt_s;
        end
    end

`ifdef RATE_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_BEATS) + 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_BEATS - 1);

    logic [RW-1:0] rep_cnt_r;

    assign rep_fire_s = (hold_r == HOLD_HELD) & ~leave_s & beat &
                        (rep_cnt_r == REP_LAST);

    // Repeat beat counter; held at zero outside HELD so entering HELD
    // always starts a full interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_r <= '0;
        end else if ((hold_r == HOLD_IDLE) || leave_s) begin
            rep_cnt_r <= '0;
        end else if (beat) begin
            if (rep_fire_s) begin
                rep_cnt_r <= '0;
            end else begin
                rep_cnt_r <= rep_cnt_r + RW'(1);
            end
        end else begin
            rep_cnt_r <= rep_cnt_r;
        end
    end
`else
    logic unused_cfg_s;

    assign rep_fire_s   = 1'b0;
    assign unused_cfg_s = (REPEAT_BEATS > 0);
`endif

    // Direction actually applied this cycle: a fresh press wins over a repeat.
    always_comb begin
        shift_dir_s = DIR_NONE;
        if (press_dir_s != DIR_NONE) begin
            shift_dir_s = press_dir_s;
        end else if (rep_fire_s) begin
            shift_dir_s = held_dir_r;
        end else begin
            shift_dir_s = DIR_NONE;
        end
    end

    // Any shift request counts as a selection change for the divider, even
    // a saturated one that leaves the index where it is.
    assign sel_change_s = (shift_dir_s != DIR_NONE);

    // Next index with wrap/saturate at the ends; the one-hot vector is always
    // rebuilt from the index so the two can never disagree.
    always_comb begin
        idx_nxt_s = idx_r;
        case (shift_dir_s)
            DIR_LEFT: begin
                if (idx_r == IDX_MAX) begin
                    idx_nxt_s = (WRAP != 0) ? IW'(0) : idx_r;
                end else begin
                    idx_nxt_s = idx_r + IW'(1);
                end
            end
            DIR_RIGHT: begin
                if (idx_r == IW'(0)) begin
                    idx_nxt_s = (WRAP != 0) ? IDX_MAX : idx_r;
                end else begin
                    idx_nxt_s = idx_r - IW'(1);
                end
            end
            default: begin
                idx_nxt_s = idx_r;
            end
        endcase
        out_nxt_s = ONE_W << idx_nxt_s;
    end

    // Selection registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= IDX_RST;
            out_r <= ONE_W << IDX_RST;
        end else begin
            idx_r <= idx_nxt_s;
            out_r <= out_nxt_s;
        end
    end

    assign out   = out_r;
    assign index = idx_r;

    blink_divider #(
        .WIDTH (WIDTH)
    ) u_blink_divider (
        .clk   (clk),
        .rst   (rst),
        .beat  (beat),
        .index (idx_r),
        .clear (sel_change_s),
        .blink (blink)
    );

endmodule

// File: tb/tb_rate_selector.sv
// -----------------------------------------------------------------------------
// tb_rate_selector
// Directed bench for rate_selector. Two instances share the stimulus: one with
// wrap-around (dut_w) and one with saturation (dut_s), both WIDTH=4,
// RESET_INDEX=0. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_rate_selector;

    logic       clk;
    logic       rst;
    logic       beat;
    logic       shift_left;
    logic       shift_right;
    logic [3:0] out_w;
    logic [1:0] index_w;
    logic       blink_w;
    logic [3:0] out_s;
    logic [1:0] index_s;
    logic       blink_s;

    int total;
    int bad;

    rate_selector #(
        .WIDTH        (4),
        .RESET_INDEX  (0),
        .WRAP         (1),
        .REPEAT_BEATS (8)
    ) dut_w (
        .clk         (clk),
        .rst         (rst),
        .beat        (beat),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .out         (out_w),
        .index       (index_w),
        .blink       (blink_w)
    );

    rate_selector #(
        .WIDTH        (4),
        .RESET_INDEX  (0),
        .WRAP         (0),
        .REPEAT_BEATS (8)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .beat        (beat),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .out         (out_s),
        .index       (index_s),
        .blink       (blink_s)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle left pulse; the result is visible right after the sampling edge.
    task automatic pulse_left(input string tag, input logic [3:0] exp_w,
                              input logic [3:0] exp_s);
        shift_left = 1'b1;
        step();
        check({tag, "_out_w"}, 32'(out_w), 32'(exp_w));
        check({tag, "_out_s"}, 32'(out_s), 32'(exp_s));
        shift_left = 1'b0;
        step();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        beat        = 1'b0;
        shift_left  = 1'b0;
        shift_right = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state.
        check("rst_out_w",   32'(out_w),   32'h1);
        check("rst_index_w", 32'(index_w), 32'h0);
        check("rst_blink_w", 32'(blink_w), 32'h0);
        check("rst_out_s",   32'(out_s),   32'h1);

        // Four left pulses: wrap vs saturate.
        pulse_left("l1", 4'b0010, 4'b0010);
        check("l1_index_w", 32'(index_w), 32'h1);
        pulse_left("l2", 4'b0100, 4'b0100);
        pulse_left("l3", 4'b1000, 4'b1000);
        check("l3_index_w", 32'(index_w), 32'h3);
        pulse_left("l4", 4'b0001, 4'b1000);
        check("l4_index_w", 32'(index_w), 32'h0);
        check("l4_index_s", 32'(index_s), 32'h3);

        // Reset, then one right pulse at index 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        shift_right = 1'b1;
        step();
        check("r0_out_w",   32'(out_w),   32'h8);
        check("r0_index_w", 32'(index_w), 32'h3);
        check("r0_out_s",   32'(out_s),   32'h1);
        shift_right = 1'b0;
        step();

        // Simultaneous rise of both buttons: no change.
        shift_left  = 1'b1;
        shift_right = 1'b1;
        step();
        check("both_out_w", 32'(out_w), 32'h8);
        check("both_out_s", 32'(out_s), 32'h1);
        shift_left  = 1'b0;
        shift_right = 1'b0;
        step();

        // Left held for 50 cycles: exactly one shift.
        shift_left = 1'b1;
        repeat (50) step();
        check("hold_out_w", 32'(out_w), 32'h1);
        check("hold_out_s", 32'(out_s), 32'h2);
        shift_left = 1'b0;
        step();
        check("hold_rel_out_w", 32'(out_w), 32'h1);

        // Divider at index 2 with beat every cycle.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        pulse_left("d1", 4'b0010, 4'b0010);
        pulse_left("d2", 4'b0100, 4'b0100);
        beat = 1'b1;
        repeat (3) step();
        check("div_3beats_blink", 32'(blink_w), 32'h0);
        step();
        check("div_4beats_blink_w", 32'(blink_w), 32'h1);
        check("div_4beats_blink_s", 32'(blink_s), 32'h1);
        step();
        step();
        // Count is 2 here; a press restarts the period at index 3.
        shift_left = 1'b1;
        step();
        check("div_mid_out", 32'(out_w), 32'h8);
        check("div_mid_blink", 32'(blink_w), 32'h1);
        shift_left = 1'b0;
        repeat (7) step();
        check("div_7beats_blink", 32'(blink_w), 32'h1);
        step();
        check("div_8beats_blink_w", 32'(blink_w), 32'h0);
        check("div_8beats_blink_s", 32'(blink_s), 32'h0);
        repeat (3) step();

        // Reset mid-blink with left held through reset.
        rst        = 1'b1;
        shift_left = 1'b1;
        step();
        check("midrst_out",   32'(out_w),   32'h1);
        check("midrst_index", 32'(index_w), 32'h0);
        check("midrst_blink", 32'(blink_w), 32'h0);
        step();
        rst = 1'b0;
        step();
        // Index 0: blink toggles on every beat, no shift from the held level.
        check("held_rst_out",    32'(out_w),   32'h1);
        check("idx0_blink_1",    32'(blink_w), 32'h1);
        step();
        check("idx0_blink_2",    32'(blink_w), 32'h0);
        shift_left = 1'b0;
        step();
        check("held_rel_out_w",  32'(out_w), 32'h1);
        check("held_rel_out_s",  32'(out_s), 32'h1);
        beat = 1'b0;
        pulse_left("after_rst", 4'b0010, 4'b0010);

`ifdef RATE_AUTOREPEAT_EN
        // Auto-repeat: left held 20 cycles with beat every cycle.
        rst = 1'b1;
        step();
        rst  = 1'b0;
        beat = 1'b1;
        step();
        shift_left = 1'b1;
        step();
        check("rep_press", 32'(out_w), 32'h2);
        repeat (7) step();
        check("rep_7", 32'(out_w), 32'h2);
        step();
        check("rep_8", 32'(out_w), 32'h4);
        repeat (7) step();
        check("rep_15", 32'(out_w), 32'h4);
        step();
        check("rep_16_w", 32'(out_w), 32'h8);
        check("rep_16_s", 32'(out_s), 32'h8);
        repeat (3) step();
        check("rep_19", 32'(out_w), 32'h8);
        shift_left = 1'b0;
        beat       = 1'b0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
